// File: rtl/fini_pkg.sv
// rtl/fini_pkg.sv - shared constants, state encoding and id type for the FINI multiplier arbiter
package fini_pkg;

    localparam int WIDTH_DEFAULT = 6;
    localparam logic [WIDTH_DEFAULT-1:0] FAULT_CODE_DEFAULT = 6'h00;

    // RETRY is only reachable when FINI_RETRY_EN is defined
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        EXEC  = 3'd1,
        RESP  = 3'd2,
        LOCK  = 3'd3,
        RETRY = 3'd4
    } state_t;

    typedef logic req_id_t;

endpackage

// File: rtl/fini_detect_core.sv
// rtl/fini_detect_core.sv - encoded AND multiplier with codeword-validity detection
module fini_detect_core #(
    parameter int WIDTH = 6
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH-1:0] c_o,
    output logic             err_o
);

    // A codeword carries its payload twice: upper half must equal lower half.
    // Bitwise AND preserves that property, so any mismatch means a corrupted
    // operand or a fault inside the AND network.
    localparam int HALF = WIDTH / 2;

    assign c_o   = a_i & b_i;
    assign err_o = (c_o[WIDTH-1:HALF] != c_o[HALF-1:0]);

endmodule

// File: rtl/fini_mul_arbiter.sv
// rtl/fini_mul_arbiter.sv - round-robin sequencer sharing one FINI core; optional retry via FINI_RETRY_EN
module fini_mul_arbiter
    import fini_pkg::*;
#(
    parameter int               WIDTH      = WIDTH_DEFAULT,
    parameter logic [WIDTH-1:0] FAULT_CODE = FAULT_CODE_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_c,
    output logic             rsp_fault,
    output logic             alarm,
    input  logic             clear_alarm
);

    state_t           state_q;
    req_id_t          last_q;
    req_id_t          id_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             rsp_valid_q;
    req_id_t          rsp_id_q;
    logic [WIDTH-1:0] rsp_c_q;
    logic             rsp_fault_q;
    logic             alarm_q;

    req_id_t          grant_id;
    logic             grant_valid;
    logic [WIDTH-1:0] core_c;
    logic             core_err;

    fini_detect_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .a_i   (a_q),
        .b_i   (b_q),
        .c_o   (core_c),
        .err_o (core_err)
    );

    // Grant selection: a lone requester wins; on contention the one not served last wins
    always_comb begin
        grant_valid = req0_valid | req1_valid;
        grant_id    = 1'b0;
        if (req0_valid && req1_valid) begin
            grant_id = ~last_q;
        end else if (req1_valid) begin
            grant_id = 1'b1;
        end
        req0_ready = (state_q == IDLE) && req0_valid && (grant_id == 1'b0);
        req1_ready = (state_q == IDLE) && req1_valid && (grant_id == 1'b1);
    end

    // Sequencer: accept, evaluate (optionally twice), present response, lock on fault
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            last_q      <= 1'b1;
            id_q        <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= 1'b0;
            rsp_c_q     <= '0;
            rsp_fault_q <= 1'b0;
            alarm_q     <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (grant_valid) begin
                        a_q     <= grant_id ? req1_a : req0_a;
                        b_q     <= grant_id ? req1_b : req0_b;
                        id_q    <= grant_id;
                        last_q  <= grant_id;
                        state_q <= EXEC;
                    end
                end
                EXEC, RETRY: begin
`ifdef FINI_RETRY_EN
                    if (core_err && (state_q == EXEC)) begin
                        state_q <= RETRY;
                    end else
`endif
                    begin
                        // the raw product is discarded whenever detection fires
                        rsp_valid_q <= 1'b1;
                        rsp_id_q    <= id_q;
                        rsp_fault_q <= core_err;
                        rsp_c_q     <= core_err ? FAULT_CODE : core_c;
                        alarm_q     <= alarm_q | core_err;
                        state_q     <= RESP;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= alarm_q ? LOCK : IDLE;
                    end
                end
                LOCK: begin
                    if (clear_alarm) begin
                        alarm_q <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_c     = rsp_c_q;
    assign rsp_fault = rsp_fault_q;
    assign alarm     = alarm_q;

endmodule

// File: tb/tb_fini_mul_arbiter.sv
// tb/tb_fini_mul_arbiter.sv - scoreboard bench for fini_mul_arbiter
module tb_fini_mul_arbiter;

    typedef struct packed {
        logic       id;
        logic [5:0] c;
        logic       fault;
    } rsp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req0_valid = 1'b0, req1_valid = 1'b0;
    logic       req0_ready, req1_ready;
    logic [5:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic       rsp_valid, rsp_ready = 1'b0, rsp_id, rsp_fault, alarm;
    logic [5:0] rsp_c;
    logic       clear_alarm = 1'b0;

    int   checks = 0;
    int   errors = 0;
    rsp_t exp_q[$];

    // reference model state
    bit   busy = 0, locked = 0, cur_fault = 0, last_id = 1;
    int   age = 0;

    always #5 clk = ~clk;

    fini_mul_arbiter dut (
        .clk         (clk),
        .rst         (rst),
        .req0_valid  (req0_valid),
        .req0_ready  (req0_ready),
        .req0_a      (req0_a),
        .req0_b      (req0_b),
        .req1_valid  (req1_valid),
        .req1_ready  (req1_ready),
        .req1_a      (req1_a),
        .req1_b      (req1_b),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_id      (rsp_id),
        .rsp_c       (rsp_c),
        .rsp_fault   (rsp_fault),
        .alarm       (alarm),
        .clear_alarm (clear_alarm)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // a codeword repeats its 3-bit payload in both halves
    function automatic bit is_codeword(input logic [5:0] c);
        return (int'(c) / 8) == (int'(c) % 8);
    endfunction

    function automatic logic [5:0] rand_op();
        logic [2:0] p;
        p = 3'($urandom_range(0, 7));
        if ($urandom_range(0, 9) < 8) return {p, p};
        return 6'($urandom_range(0, 63));
    endfunction

    // Drive one cycle of inputs, predict and check handshakes, update the model.
    task automatic cycle(input logic v0, input logic [5:0] a0, input logic [5:0] b0,
                         input logic v1, input logic [5:0] a1, input logic [5:0] b1,
                         input logic rr, input logic clr);
        bit e0, e1, erv, ealarm, f, id;
        logic [5:0] a, b, c;
        req0_valid = v0; req0_a = a0; req0_b = b0;
        req1_valid = v1; req1_a = a1; req1_b = b1;
        rsp_ready = rr; clear_alarm = clr;
        @(negedge clk);
        if (busy) age++;
        e0 = 0; e1 = 0;
        if (!busy && !locked) begin
            if (v0 && v1) begin
                if (last_id) e0 = 1; else e1 = 1;
            end else if (v0) e0 = 1;
            else if (v1) e1 = 1;
        end
        erv    = busy && (age >= 2);
        ealarm = locked || (erv && cur_fault);
        chk("req0_ready", req0_ready, e0);
        chk("req1_ready", req1_ready, e1);
        chk("rsp_valid", rsp_valid, erv);
        chk("alarm", alarm, ealarm);
        if (locked && clr) locked = 0;
        if (erv && rr) begin
            busy = 0;
            if (cur_fault) locked = 1;
        end
        if (e0 || e1) begin
            id = e1;
            a  = e1 ? a1 : a0;
            b  = e1 ? b1 : b0;
            c  = a & b;
            f  = !is_codeword(c);
            exp_q.push_back('{id: id, c: (f ? 6'h00 : c), fault: f});
            busy = 1; age = 0; cur_fault = f; last_id = id;
        end
        @(posedge clk); #1;
    endtask

    task automatic idle_cycle(input logic rr, input logic clr);
        cycle(0, 6'h00, 6'h00, 0, 6'h00, 6'h00, rr, clr);
    endtask

    // Asynchronous reset pulse starting mid-cycle; outputs must drop at once.
    task automatic hit_reset();
        #2;
        req0_valid = 0; req1_valid = 0; rsp_ready = 0; clear_alarm = 0;
        rst = 1;
        #1;
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_alarm", alarm, 0);
        chk("rst_rsp_c", rsp_c, 0);
        chk("rst_rsp_fault", rsp_fault, 0);
        chk("rst_rsp_id", rsp_id, 0);
        chk("rst_ready", {req0_ready, req1_ready}, 0);
        @(posedge clk); #1;
        rst = 0;
        exp_q.delete();
        busy = 0; locked = 0; cur_fault = 0; last_id = 1; age = 0;
    endtask

    // Scoreboard monitor: every presented response must match the oldest expectation
    initial begin
        rsp_t e;
        forever begin
            @(negedge clk); #1;
            if (!rst && rsp_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL rsp_unexpected: got id=%0d c=%0h with no pending request", rsp_id, rsp_c);
                end else begin
                    e = exp_q[0];
                    chk("rsp_id", rsp_id, e.id);
                    chk("rsp_c", rsp_c, e.c);
                    chk("rsp_fault", rsp_fault, e.fault);
                    if (rsp_ready) void'(exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        repeat (2) @(posedge clk);
        #1 rst = 0;
        // reset state
        chk("reset_rsp_c", rsp_c, 0);
        chk("reset_rsp_id", rsp_id, 0);
        chk("reset_rsp_fault", rsp_fault, 0);
        idle_cycle(1, 0);

        // single transaction, immediate consumer, IDLE again at t+3
        cycle(1, 6'h3F, 6'h3F, 0, 6'h00, 6'h00, 1, 0);
        idle_cycle(1, 0);
        idle_cycle(1, 0);
        cycle(1, 6'h12, 6'h3F, 0, 6'h00, 6'h00, 1, 0);
        repeat (3) idle_cycle(1, 0);

        // contention after reset: grants alternate 0,1,0,1,0,1
        hit_reset();
        repeat (18) cycle(1, 6'h2D, 6'h3F, 1, 6'h1B, 6'h3F, 1, 0);
        repeat (3) idle_cycle(1, 0);

        // fault from requester 1, lockout while valid held, then clear
        cycle(0, 6'h00, 6'h00, 1, 6'h01, 6'h3F, 1, 0);
        repeat (5) cycle(1, 6'h3F, 6'h3F, 1, 6'h3F, 6'h3F, 1, 0);
        cycle(1, 6'h3F, 6'h3F, 1, 6'h3F, 6'h3F, 1, 1);
        cycle(1, 6'h3F, 6'h3F, 0, 6'h00, 6'h00, 1, 0);
        repeat (3) idle_cycle(1, 0);

        // response held for several cycles, no new grant, then single handshake
        cycle(1, 6'h24, 6'h3F, 0, 6'h00, 6'h00, 0, 0);
        repeat (7) cycle(1, 6'h3F, 6'h3F, 1, 6'h09, 6'h3F, 0, 0);
        idle_cycle(1, 0);
        repeat (2) idle_cycle(1, 0);

        // reset while in EXEC: no response, requester 0 favoured afterwards
        cycle(0, 6'h00, 6'h00, 1, 6'h3F, 6'h3F, 1, 0);
        hit_reset();
        repeat (3) idle_cycle(1, 0);
        cycle(1, 6'h09, 6'h3F, 1, 6'h12, 6'h3F, 1, 0);
        repeat (3) idle_cycle(1, 0);

        // reset while a faulted response is pending clears alarm
        cycle(1, 6'h01, 6'h3F, 0, 6'h00, 6'h00, 0, 0);
        idle_cycle(0, 0);
        idle_cycle(0, 0);
        hit_reset();
        repeat (3) idle_cycle(1, 0);

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            cycle(1'($urandom_range(0, 1)), rand_op(), rand_op(),
                  1'($urandom_range(0, 1)), rand_op(), rand_op(),
                  1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0));
        end

        // drain
        repeat (6) idle_cycle(1, 1);
        chk("drain_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
